// File: rtl/sbus_mem_target.sv
// Simple-bus memory target: req/gnt ownership, start/rdy transfers, wait states and burst reads.
// Optional address-error strobe on the err port when SBUS_ERR_EN is defined.
module sbus_mem_target #(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1,
  parameter int BURST_LEN   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  output logic          gnt,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          rdy
`ifdef SBUS_ERR_EN
  ,
  output logic          err
`endif
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int BW = $clog2(BURST_LEN + 1);

  localparam logic [1:0] M_READ  = 2'b00;
  localparam logic [1:0] M_WRITE = 2'b01;
  localparam logic [1:0] M_BURST = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_ACCESS} state_t;

  state_t        state, next_state;
  logic [WW-1:0] wcnt;
  logic [BW-1:0] bcnt;
  logic [AW-1:0] a_q;
  logic [1:0]    mode_q;
  logic [DW-1:0] wdata_q;

  logic [DW-1:0] mem [DEPTH];

  logic          launch, beat, oob;
  logic [AW-1:0] beat_addr, a_nxt;
  logic [1:0]    beat_mode;
  logic [DW-1:0] beat_wdata;
  logic [IW-1:0] idx;
  logic [BW-1:0] blen;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (req) next_state = S_GRANT;
      S_GRANT:  if (start) next_state = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                else if (!req) next_state = S_IDLE;
      S_WAIT:   if (wcnt == WW'(1)) next_state = S_ACCESS;
      S_ACCESS: if (bcnt != '0) next_state = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                else next_state = req ? S_GRANT : S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // A beat is performed on the edge that enters ACCESS, so rdy/rdata are
  // registered and visible during the ACCESS cycle itself.
  always_comb begin
    launch     = (state == S_GRANT) && start;
    beat       = (next_state == S_ACCESS);
    beat_addr  = (state == S_GRANT) ? addr  : a_q;
    beat_mode  = (state == S_GRANT) ? mode  : mode_q;
    beat_wdata = (state == S_GRANT) ? wdata : wdata_q;
    idx        = IW'(32'(beat_addr) % 32'(DEPTH));
    a_nxt      = (32'(beat_addr) == 32'(DEPTH - 1)) ? '0 : beat_addr + AW'(1);
    blen       = (mode == M_BURST) ? BW'(BURST_LEN) : BW'(1);
`ifdef SBUS_ERR_EN
    oob        = 32'(beat_addr) >= 32'(DEPTH);
`else
    oob        = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      gnt     <= 1'b0;
      rdy     <= 1'b0;
      rdata   <= '0;
      wcnt    <= '0;
      bcnt    <= '0;
      a_q     <= '0;
      mode_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= next_state;
      gnt   <= (next_state != S_IDLE);
      rdy   <= beat;
      if (launch) begin
        mode_q  <= mode;
        wdata_q <= wdata;
        bcnt    <= blen - BW'(beat);
        a_q     <= beat ? a_nxt : addr;
        wcnt    <= WW'(WAIT_STATES);
      end else begin
        if (beat) begin
          bcnt <= bcnt - BW'(1);
          a_q  <= a_nxt;
        end
        if (state == S_WAIT) wcnt <= wcnt - WW'(1);
        if (state == S_ACCESS && next_state == S_WAIT) wcnt <= WW'(WAIT_STATES);
      end
      if (beat) begin
        if (oob) rdata <= '0;
        else if (beat_mode == M_READ || beat_mode == M_BURST) rdata <= mem[idx];
      end
    end
  end

`ifdef SBUS_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= beat && oob;
  end
`endif

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (beat && beat_mode == M_WRITE && !oob) mem[idx] <= beat_wdata;
  end

endmodule

// File: tb/tb_sbus_mem_target.sv
// Directed bench for sbus_mem_target (DEPTH=16, WAIT_STATES=1, BURST_LEN=4).
// Builds with or without SBUS_ERR_EN; expectations switch accordingly.
module tb_sbus_mem_target;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req, start;
  logic [1:0] mode;
  logic [7:0] addr, wdata;
  logic [7:0] rdata;
  logic       gnt, rdy;
`ifdef SBUS_ERR_EN
  logic       err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sbus_mem_target #(.AW(8), .DW(8), .DEPTH(16), .WAIT_STATES(1), .BURST_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .start(start), .mode(mode),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rdy(rdy)
`ifdef SBUS_ERR_EN
    , .err(err)
`endif
  );

  typedef struct packed {
    logic [1:0]  m;
    logic [7:0]  a;
    logic [7:0]  d;
    logic [2:0]  nb;
    logic [31:0] r;   // beat i expected rdata in r[8*i +: 8]
    logic        e;   // expected err on every beat
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nseen;
    logic [7:0] v8;
    rst_n = 1'b0; req = 1'b0; start = 1'b0; mode = 2'b00; addr = '0; wdata = '0;

    // vectors: mode, addr, wdata, beats, expected rdata per beat, err
    tbl[0]  = '{2'b01, 8'h03, 8'h5A, 3'd1, 32'h0000_0000, 1'b0};
    tbl[1]  = '{2'b00, 8'h03, 8'h00, 3'd1, 32'h0000_005A, 1'b0};
    tbl[2]  = '{2'b01, 8'h0E, 8'h01, 3'd1, 32'h0000_005A, 1'b0};
    tbl[3]  = '{2'b01, 8'h0F, 8'h02, 3'd1, 32'h0000_005A, 1'b0};
    tbl[4]  = '{2'b01, 8'h00, 8'h03, 3'd1, 32'h0000_005A, 1'b0};
    tbl[5]  = '{2'b01, 8'h01, 8'h04, 3'd1, 32'h0000_005A, 1'b0};
    tbl[6]  = '{2'b10, 8'h0E, 8'h00, 3'd4, 32'h0403_0201, 1'b0};
`ifdef SBUS_ERR_EN
    tbl[7]  = '{2'b01, 8'h13, 8'h77, 3'd1, 32'h0000_0000, 1'b1};
    v8 = 8'h5A;
`else
    tbl[7]  = '{2'b01, 8'h13, 8'h77, 3'd1, 32'h0000_0004, 1'b0};
    v8 = 8'h77;
`endif
    tbl[8]  = '{2'b00, 8'h03, 8'h00, 3'd1, {24'h0, v8}, 1'b0};
    tbl[9]  = '{2'b11, 8'h03, 8'hEE, 3'd1, {24'h0, v8}, 1'b0};
    tbl[10] = '{2'b00, 8'h03, 8'h00, 3'd1, {24'h0, v8}, 1'b0};
    tbl[11] = '{2'b01, 8'h02, 8'h99, 3'd1, {24'h0, v8}, 1'b0};
    tbl[12] = '{2'b10, 8'h0F, 8'h00, 3'd4, 32'h9904_0302, 1'b0};

    #3;
    chk("reset_gnt", {31'b0, gnt}, 0);
    chk("reset_rdy", {31'b0, rdy}, 0);
    chk("reset_rdata", {24'b0, rdata}, 0);
    #10 rst_n = 1'b1;
    req = 1'b1;
    cyc(); cyc();
    chk("gnt_after_req", {31'b0, gnt}, 1);

    foreach (tbl[i]) begin
      start = 1'b1; mode = tbl[i].m; addr = tbl[i].a; wdata = tbl[i].d;
      cyc();
      start = 1'b0; mode = 2'b00; addr = '0; wdata = '0;
      nseen = 0;
      for (int k = 2; k <= 12; k++) begin
        cyc();
        if (rdy) begin
          if (nseen < 4) begin
            chk($sformatf("v%0d_beat%0d_time", i, nseen), k, 2 + 2 * nseen);
            chk($sformatf("v%0d_beat%0d_rdata", i, nseen), {24'b0, rdata}, {24'b0, tbl[i].r[8*nseen +: 8]});
`ifdef SBUS_ERR_EN
            chk($sformatf("v%0d_beat%0d_err", i, nseen), {31'b0, err}, {31'b0, tbl[i].e});
`endif
          end
          nseen++;
        end
      end
      chk($sformatf("v%0d_beats", i), nseen, {29'b0, tbl[i].nb});
      chk($sformatf("v%0d_gnt_after", i), {31'b0, gnt}, 1);
    end

    // start while IDLE must do nothing
    req = 1'b0;
    cyc(); cyc();
    chk("idle_gnt", {31'b0, gnt}, 0);
    start = 1'b1; mode = 2'b01; addr = 8'h03; wdata = 8'h11;
    cyc();
    start = 1'b0;
    nseen = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (rdy || gnt) nseen++;
    end
    chk("idle_start_ignored", nseen, 0);

    // early release: req dropped the cycle after start
    req = 1'b1;
    cyc();
    start = 1'b1; mode = 2'b00; addr = 8'h03;
    cyc();
    start = 1'b0; req = 1'b0;
    nseen = 0;
    for (int k = 2; k <= 10 && nseen == 0; k++) begin
      cyc();
      if (rdy) begin
        nseen = k;
        chk("early_gnt_held", {31'b0, gnt}, 1);
        chk("early_rdata", {24'b0, rdata}, {24'b0, v8});
      end
    end
    chk("early_rdy_time", nseen, 2);
    cyc();
    chk("early_gnt_drop", {31'b0, gnt}, 0);
    chk("early_rdy_drop", {31'b0, rdy}, 0);

    // async reset in the middle of WAIT, rdata currently nonzero
    req = 1'b1;
    cyc();
    start = 1'b1; mode = 2'b00; addr = 8'h03;
    cyc();
    start = 1'b0;
    chk("wait_gnt", {31'b0, gnt}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_gnt", {31'b0, gnt}, 0);
    chk("async_rdy", {31'b0, rdy}, 0);
    chk("async_rdata", {24'b0, rdata}, 0);
    #10 rst_n = 1'b1;
    cyc(); cyc();
    chk("regrant_gnt", {31'b0, gnt}, 1);
    chk("regrant_rdy", {31'b0, rdy}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
